spike_rate_decoder: RTL

Receiving end of the neuron spike interface. Samples a 1-bit spike train (as driven by the neuron's spike output) and decodes it into an 8-bit spike-count rate over a fixed window of clock cycles. Each completed window's result is offered downstream on a valid/ready handshake. Sits between a neuron array and readout/learning logic, converting spike trains back into magnitudes.

---
 rtl/snn_pkg.sv | 24 ++
 rtl/spike_isi_meter.sv | 68 ++++++
 rtl/spike_rate_decoder.sv | 118 +++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// snn_pkg -- shared definitions for the spiking-neural-network blocks.
//   state_e  : decoder FSM states (IDLE, COUNT)
//   DEF_*    : default window length / count width / window counter width
//   sat_inc  : saturating increment on a 32-bit carrier. Callers cast to their
//              own width, so widths up to 32 bits are supported.
package snn_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    localparam int DEF_WINDOW = 100;
    localparam int DEF_CNT_W  = 8;
    localparam int DEF_WIN_W  = 16;

    function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                            input logic        inc,
                                            input logic [31:0] maxv);
        if (inc && (v < maxv)) return v + 32'd1;
        return v;
    endfunction

endpackage

// File: rtl/spike_isi_meter.sv
// spike_isi_meter -- inter-spike interval measurement.
//   clk, rst_n : clock, synchronous active-low reset
//   active     : decoder is counting this cycle; low clears the meter
//   spike_in   : spike sample
//   isi        : cycles between the last two spikes (saturating)
//   isi_valid  : one-cycle pulse when isi is updated
// The first spike after activation only arms the meter. intv_q holds the
// cycles elapsed since the previous spike minus one, so the reported interval
// is intv_q + 1 (spikes at cycles 5 and 12 report 7).
module spike_isi_meter
    import snn_pkg::*;
#(
    parameter int WIN_W = DEF_WIN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    input  logic             spike_in,
    output logic [WIN_W-1:0] isi,
    output logic             isi_valid
);

    localparam logic [31:0] INTV_MAX = 32'((64'd1 << WIN_W) - 64'd1);

    logic [WIN_W-1:0] intv_q, intv_d, intv_next;
    logic [WIN_W-1:0] isi_q, isi_d;
    logic             armed_q, armed_d;
    logic             isi_valid_q, isi_valid_d;

    always_comb begin
        intv_d      = intv_q;
        isi_d       = isi_q;
        armed_d     = armed_q;
        isi_valid_d = 1'b0;
        intv_next   = WIN_W'(sat_inc(32'(intv_q), 1'b1, INTV_MAX));
        if (!active) begin
            intv_d  = '0;
            armed_d = 1'b0;
        end else if (spike_in) begin
            if (armed_q) begin
                isi_d       = intv_next;
                isi_valid_d = 1'b1;
            end
            intv_d  = '0;
            armed_d = 1'b1;
        end else begin
            intv_d = intv_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            intv_q      <= '0;
            isi_q       <= '0;
            armed_q     <= 1'b0;
            isi_valid_q <= 1'b0;
        end else begin
            intv_q      <= intv_d;
            isi_q       <= isi_d;
            armed_q     <= armed_d;
            isi_valid_q <= isi_valid_d;
        end
    end

    assign isi       = isi_q;
    assign isi_valid = isi_valid_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder -- counts spikes over a fixed window of WINDOW cycles and
// offers each window's count on a valid/ready handshake.
//   clk, rst_n  : clock, synchronous active-low reset
//   enable      : high decodes; low returns to IDLE, discarding partial window
//   spike_in    : spike sample, one per cycle
//   rate        : saturated spike count of the last completed window
//   rate_valid  : rate holds an unconsumed result
//   rate_ready  : downstream accept
//   overrun     : sticky, a result was replaced before being accepted
//   busy        : FSM is in COUNT
//   isi, isi_valid : inter-spike interval outputs (only with ISI_DECODE_EN)
// Optional feature macro: ISI_DECODE_EN.
// A low enable takes priority over a window close in the same cycle.
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int WINDOW = DEF_WINDOW,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int WIN_W  = DEF_WIN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             spike_in,
    output logic [CNT_W-1:0] rate,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             overrun,
`ifdef ISI_DECODE_EN
    output logic [WIN_W-1:0] isi,
    output logic             isi_valid,
`endif
    output logic             busy
);

    localparam logic [31:0]      SPK_MAX  = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    state_e           state_q, state_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] spk_cnt_q, spk_cnt_d, spk_next;
    logic [CNT_W-1:0] rate_q, rate_d;
    logic             rate_valid_q, rate_valid_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        state_d      = state_q;
        win_cnt_d    = win_cnt_q;
        spk_cnt_d    = spk_cnt_q;
        rate_d       = rate_q;
        rate_valid_d = rate_valid_q;
        overrun_d    = overrun_q;
        spk_next     = CNT_W'(sat_inc(32'(spk_cnt_q), spike_in, SPK_MAX));

        if (rate_valid_q && rate_ready) rate_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                win_cnt_d = '0;
                spk_cnt_d = '0;
                if (enable) state_d = COUNT;
            end
            COUNT: begin
                if (!enable) begin
                    state_d   = IDLE;
                    win_cnt_d = '0;
                    spk_cnt_d = '0;
                end else if (win_cnt_q == WIN_LAST) begin
                    // Close: an unaccepted older result is replaced and flagged.
                    rate_d       = spk_next;
                    rate_valid_d = 1'b1;
                    if (rate_valid_q && !rate_ready) overrun_d = 1'b1;
                    win_cnt_d    = '0;
                    spk_cnt_d    = '0;
                end else begin
                    win_cnt_d = win_cnt_q + 1'b1;
                    spk_cnt_d = spk_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            win_cnt_q    <= '0;
            spk_cnt_q    <= '0;
            rate_q       <= '0;
            rate_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_cnt_q    <= win_cnt_d;
            spk_cnt_q    <= spk_cnt_d;
            rate_q       <= rate_d;
            rate_valid_q <= rate_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rate       = rate_q;
    assign rate_valid = rate_valid_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q == COUNT);

`ifdef ISI_DECODE_EN
    spike_isi_meter #(.WIN_W(WIN_W)) u_isi (
        .clk      (clk),
        .rst_n    (rst_n),
        .active   (busy && enable),
        .spike_in (spike_in),
        .isi      (isi),
        .isi_valid(isi_valid)
    );
`endif

endmodule
